// File: rtl/dtt_xbar_pkg.sv
// Shared types and helpers for the crossbar output arbiter.
package dtt_xbar_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;

  localparam int MAX_IN = 32;

  function automatic int credit_w(input int credits);
    return $clog2(credits + 1);
  endfunction

  // Index of the first set bit strictly after ptr, wrapping within n; -1 if none.
  function automatic int rr_first(input logic [MAX_IN-1:0] req, input int n, input int ptr);
    int idx;
    int pos;
    pos = -1;
    for (int k = 1; k <= MAX_IN; k++) begin
      idx = (ptr + k) % n;
      pos = (k <= n && pos < 0 && req[idx]) ? idx : pos;
    end
    return pos;
  endfunction

endpackage

// File: rtl/dtt_xbar_arbiter_if.sv
// Requester/crossbar handshake bundle seen by the output arbiter.
interface dtt_xbar_arbiter_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int IDX_W = $clog2(N_IN)
) ();
  logic [N_IN-1:0]             req_valid;
  logic [N_IN-1:0][N_OUT-1:0]  req_dest;
  logic [N_IN-1:0]             req_last;
  logic [N_IN-1:0]             req_ready;
  logic [N_OUT-1:0][IDX_W-1:0] xbar_sel;
  logic [N_OUT-1:0]            xbar_valid;
  logic [N_OUT-1:0]            credit_return;
  logic [N_OUT-1:0]            out_enable;
  logic [N_IN-1:0]             drop_err;

  modport slave (
    input  req_valid, req_dest, req_last, credit_return, out_enable,
    output req_ready, xbar_sel, xbar_valid, drop_err
  );

  modport master (
    output req_valid, req_dest, req_last, credit_return, out_enable,
    input  req_ready, xbar_sel, xbar_valid, drop_err
  );
endinterface

// File: rtl/dtt_rr_arbiter.sv
// One crossbar output: round-robin pick, packet lock, and downstream credit count.
module dtt_rr_arbiter
  import dtt_xbar_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int CREDITS  = 4,
  parameter int IDX_W    = $clog2(N_IN),
  parameter int CREDIT_W = credit_w(CREDITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  i_req,
  input  logic [N_IN-1:0]  i_last,
  input  logic             i_enable,
  input  logic             i_credit_return,
  output logic [N_IN-1:0]  o_grant,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  arb_state_e          r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_owner, w_owner_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                w_eligible;
  int                  w_pos;

  assign w_eligible = i_enable && (r_credit != '0);
  assign w_pos      = rr_first(MAX_IN'(i_req), N_IN, int'(r_ptr));

  // Grant selection; a locked output only ever serves its owner
  always_comb begin
    o_valid     = 1'b0;
    o_idx       = '0;
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    if (!w_eligible) begin
      o_valid = 1'b0;
    end else if (r_state == LOCKED) begin
      if (i_req[r_owner]) begin
        o_valid     = 1'b1;
        o_idx       = r_owner;
        w_state_nxt = i_last[r_owner] ? IDLE : LOCKED;
      end else begin
        o_valid = 1'b0;
      end
    end else if (w_pos >= 0) begin
      o_valid   = 1'b1;
      o_idx     = IDX_W'(w_pos);
      w_ptr_nxt = IDX_W'(w_pos);
      if (i_last[IDX_W'(w_pos)]) begin
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = LOCKED;
        w_owner_nxt = IDX_W'(w_pos);
      end
    end else begin
      o_valid = 1'b0;
    end
    o_grant = o_valid ? (N_IN'(1) << o_idx) : '0;
  end

  // Credit bookkeeping; a return at full count is ignored
  always_comb begin
    w_credit_nxt = r_credit;
    case ({o_valid, i_credit_return})
      2'b10:   w_credit_nxt = r_credit - CREDIT_W'(1);
      2'b01:   w_credit_nxt = (r_credit == CREDIT_W'(CREDITS)) ? r_credit : r_credit + CREDIT_W'(1);
      default: w_credit_nxt = r_credit;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_ptr    <= IDX_W'(N_IN - 1);
      r_credit <= CREDIT_W'(CREDITS);
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_credit <= w_credit_nxt;
    end
  end

endmodule

// File: rtl/dtt_xbar_arbiter.sv
// Per-output scheduler in front of the crossbar: decodes destinations, runs one
// arbiter per output, merges grants into req_ready, and flags illegal-dest drops.
module dtt_xbar_arbiter
  import dtt_xbar_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 4,
  parameter int CREDITS = 4,
  parameter int IDX_W   = $clog2(N_IN)
) (
  input logic               clk,
  input logic               rst_n,
  dtt_xbar_arbiter_if.slave bus
);

  logic [N_IN-1:0]             w_legal;
  logic [N_IN-1:0]             w_drop;
  logic [N_IN-1:0]             w_ready;
  logic [N_OUT-1:0][N_IN-1:0]  w_req;
  logic [N_OUT-1:0][N_IN-1:0]  w_grant;
  logic [N_OUT-1:0]            w_valid;
  logic [N_OUT-1:0][IDX_W-1:0] w_sel;
  logic [N_IN-1:0]             r_drop_err;

  // Destination decode into per-output request vectors
  always_comb begin
    w_legal = '0;
    w_drop  = '0;
    w_req   = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_legal[i] = bus.req_dest[i] < N_OUT'(N_OUT);
      w_drop[i]  = bus.req_valid[i] && !w_legal[i];
      for (int j = 0; j < N_OUT; j++) begin
        w_req[j][i] = bus.req_valid[i] && w_legal[i] && (bus.req_dest[i] == N_OUT'(j));
      end
    end
  end

  // Illegal beats are accepted immediately so the requester never blocks on them
  always_comb begin
    w_ready = w_drop;
    for (int j = 0; j < N_OUT; j++) begin
      w_ready = w_ready | w_grant[j];
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    dtt_rr_arbiter #(
      .N_IN    (N_IN),
      .CREDITS (CREDITS),
      .IDX_W   (IDX_W)
    ) u_arb (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_req           (w_req[j]),
      .i_last          (bus.req_last),
      .i_enable        (bus.out_enable[j]),
      .i_credit_return (bus.credit_return[j]),
      .o_grant         (w_grant[j]),
      .o_valid         (w_valid[j]),
      .o_idx           (w_sel[j])
    );
  end

  // Drop error pulse, one cycle after the dropped beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_err <= '0;
    end else begin
      r_drop_err <= w_drop;
    end
  end

  // Grant outputs are combinational, so hold them quiet while reset is asserted
  assign bus.req_ready  = rst_n ? w_ready : '0;
  assign bus.xbar_valid = rst_n ? w_valid : '0;
  assign bus.xbar_sel   = rst_n ? w_sel : '0;
  assign bus.drop_err   = r_drop_err;

endmodule

// File: tb/tb_dtt_xbar_arbiter.sv
// Self-checking bench: directed scenarios plus constrained-random traffic against a
// behavioural scheduler model.
module tb_dtt_xbar_arbiter;

  localparam int N = 4;
  localparam int C = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dtt_xbar_arbiter_if #(.N_IN(N), .N_OUT(N), .IDX_W(2)) bus ();

  dtt_xbar_arbiter #(.N_IN(N), .N_OUT(N), .CREDITS(C), .IDX_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: per output credit, last winner, lock flag and owner
  int         m_cred[N];
  int         m_ptr[N];
  int         m_own[N];
  bit         m_lock[N];
  logic [3:0] m_drop;

  logic [3:0]      obs_ready;
  logic [3:0]      obs_valid;
  logic [3:0]      obs_drop;
  logic [3:0][1:0] obs_sel;

  task automatic reset_model();
    for (int j = 0; j < N; j++) begin
      m_cred[j] = C;
      m_ptr[j]  = N - 1;
      m_own[j]  = 0;
      m_lock[j] = 1'b0;
    end
    m_drop = 4'b0000;
  endtask

  task automatic idle_inputs();
    bus.req_valid     = 4'b0000;
    bus.req_dest      = '0;
    bus.req_last      = 4'b0000;
    bus.credit_return = 4'b0000;
    bus.out_enable    = 4'b1111;
  endtask

  task automatic set_in(input int i, input bit v, input int d, input bit l);
    bus.req_valid[i] = v;
    bus.req_dest[i]  = 4'(d);
    bus.req_last[i]  = l;
  endtask

  // Called at posedge+1 with inputs driven; checks outputs, advances model one edge
  task automatic cycle(input string tag);
    logic [3:0] e_ready;
    logic [3:0] e_valid;
    int         e_sel[N];
    int         win;
    #2;
    e_ready = 4'b0000;
    e_valid = 4'b0000;
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && bus.req_dest[i] >= 4'd4) e_ready[i] = 1'b1;
    end
    for (int j = 0; j < N; j++) begin
      e_sel[j] = 0;
      win = -1;
      if (bus.out_enable[j] && m_cred[j] > 0) begin
        if (m_lock[j]) begin
          if (bus.req_valid[m_own[j]] && int'(bus.req_dest[m_own[j]]) == j) win = m_own[j];
        end else begin
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr[j] + k) % N;
            if (win < 0 && bus.req_valid[c] && int'(bus.req_dest[c]) == j) win = c;
          end
        end
      end
      if (win >= 0) begin
        e_valid[j]   = 1'b1;
        e_sel[j]     = win;
        e_ready[win] = 1'b1;
      end
    end
    obs_ready = bus.req_ready;
    obs_valid = bus.xbar_valid;
    obs_sel   = bus.xbar_sel;
    obs_drop  = bus.drop_err;
    checks++;
    if (obs_ready !== e_ready) begin
      errors++;
      $display("FAIL %s req_ready got=%b exp=%b", tag, obs_ready, e_ready);
    end
    checks++;
    if (obs_valid !== e_valid) begin
      errors++;
      $display("FAIL %s xbar_valid got=%b exp=%b", tag, obs_valid, e_valid);
    end
    for (int j = 0; j < N; j++) begin
      if (e_valid[j]) begin
        checks++;
        if (obs_sel[j] !== 2'(e_sel[j])) begin
          errors++;
          $display("FAIL %s xbar_sel[%0d] got=%0d exp=%0d", tag, j, obs_sel[j], e_sel[j]);
        end
      end
    end
    checks++;
    if (obs_drop !== m_drop) begin
      errors++;
      $display("FAIL %s drop_err got=%b exp=%b", tag, obs_drop, m_drop);
    end
    @(posedge clk);
    for (int j = 0; j < N; j++) begin
      if (e_valid[j] && !bus.credit_return[j]) m_cred[j]--;
      else if (!e_valid[j] && bus.credit_return[j] && m_cred[j] < C) m_cred[j]++;
      if (e_valid[j]) begin
        if (m_lock[j]) begin
          if (bus.req_last[m_own[j]]) m_lock[j] = 1'b0;
        end else begin
          m_ptr[j] = e_sel[j];
          if (!bus.req_last[e_sel[j]]) begin
            m_lock[j] = 1'b1;
            m_own[j]  = e_sel[j];
          end
        end
      end
    end
    for (int i = 0; i < N; i++) m_drop[i] = bus.req_valid[i] && bus.req_dest[i] >= 4'd4;
    #1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < N; i++) set_in(i, 1'b1, i, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset req_ready got=%b exp=0000", bus.req_ready); end
    checks++;
    if (bus.xbar_valid !== 4'b0000) begin errors++; $display("FAIL reset xbar_valid got=%b exp=0000", bus.xbar_valid); end
    checks++;
    if (bus.xbar_sel !== 8'h00) begin errors++; $display("FAIL reset xbar_sel got=%h exp=00", bus.xbar_sel); end
    checks++;
    if (bus.drop_err !== 4'b0000) begin errors++; $display("FAIL reset drop_err got=%b exp=0000", bus.drop_err); end
    reset_dut();
  endtask

  task automatic test_contention();
    reset_dut();
    set_in(0, 1'b1, 2, 1'b1);
    set_in(1, 1'b1, 2, 1'b1);
    set_in(2, 1'b1, 1, 1'b1);
    set_in(3, 1'b1, 3, 1'b1);
    cycle("contend1");
    checks++;
    if (obs_ready !== 4'b1101 || obs_sel[2] !== 2'd0 || obs_sel[1] !== 2'd2 || obs_sel[3] !== 2'd3) begin
      errors++;
      $display("FAIL contend1 ready=%b sel2=%0d sel1=%0d sel3=%0d exp ready=1101 sel 0/2/3", obs_ready, obs_sel[2], obs_sel[1], obs_sel[3]);
    end
    set_in(0, 1'b0, 0, 1'b0);
    set_in(2, 1'b0, 0, 1'b0);
    set_in(3, 1'b0, 0, 1'b0);
    cycle("contend2");
    checks++;
    if (obs_ready !== 4'b0010 || obs_sel[2] !== 2'd1) begin
      errors++;
      $display("FAIL contend2 ready=%b sel2=%0d exp ready=0010 sel2=1", obs_ready, obs_sel[2]);
    end
  endtask

  task automatic test_alternate();
    reset_dut();
    set_in(0, 1'b1, 0, 1'b1);
    set_in(1, 1'b1, 0, 1'b1);
    bus.credit_return[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle("alternate");
      checks++;
      if (obs_valid[0] !== 1'b1 || obs_sel[0] !== 2'(k % 2)) begin
        errors++;
        $display("FAIL alternate beat %0d valid=%b sel=%0d exp sel=%0d", k, obs_valid[0], obs_sel[0], k % 2);
      end
    end
  endtask

  task automatic test_lock();
    reset_dut();
    set_in(1, 1'b1, 2, 1'b0);
    cycle("lock_b1");
    set_in(0, 1'b1, 2, 1'b1);
    cycle("lock_b2");
    checks++;
    if (obs_ready !== 4'b0010) begin errors++; $display("FAIL lock_b2 ready got=%b exp=0010", obs_ready); end
    set_in(1, 1'b0, 2, 1'b0);
    cycle("lock_stall");
    checks++;
    if (obs_valid[2] !== 1'b0 || obs_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL lock_stall valid2=%b ready0=%b exp 0/0", obs_valid[2], obs_ready[0]);
    end
    set_in(1, 1'b1, 2, 1'b1);
    cycle("lock_b3");
    checks++;
    if (obs_ready !== 4'b0010) begin errors++; $display("FAIL lock_b3 ready got=%b exp=0010", obs_ready); end
    set_in(1, 1'b0, 0, 1'b0);
    cycle("lock_release");
    checks++;
    if (obs_ready !== 4'b0001 || obs_sel[2] !== 2'd0) begin
      errors++;
      $display("FAIL lock_release ready=%b sel2=%0d exp 0001/0", obs_ready, obs_sel[2]);
    end
  endtask

  task automatic test_credits();
    logic [11:0] ret_tab;
    logic [11:0] rdy_tab;
    ret_tab = 12'b0011_0010_0000;
    rdy_tab = 12'b0110_0100_1111;
    reset_dut();
    set_in(2, 1'b1, 1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      bus.credit_return[1] = ret_tab[k];
      cycle("credits");
      checks++;
      if (obs_ready[2] !== rdy_tab[k]) begin
        errors++;
        $display("FAIL credits step %0d ready2 got=%b exp=%b", k, obs_ready[2], rdy_tab[k]);
      end
    end
  endtask

  task automatic test_illegal();
    reset_dut();
    set_in(3, 1'b1, 5, 1'b0);
    cycle("illegal");
    checks++;
    if (obs_ready[3] !== 1'b1 || obs_valid !== 4'b0000 || obs_drop !== 4'b0000) begin
      errors++;
      $display("FAIL illegal ready3=%b valid=%b drop=%b exp 1/0000/0000", obs_ready[3], obs_valid, obs_drop);
    end
    set_in(3, 1'b0, 0, 1'b0);
    cycle("illegal_pulse");
    checks++;
    if (obs_drop !== 4'b1000) begin errors++; $display("FAIL illegal_pulse drop got=%b exp=1000", obs_drop); end
    cycle("illegal_end");
    checks++;
    if (obs_drop !== 4'b0000) begin errors++; $display("FAIL illegal_end drop got=%b exp=0000", obs_drop); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    set_in(1, 1'b1, 0, 1'b0);
    cycle("ar_lock");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.xbar_valid !== 4'b0000 || bus.xbar_sel !== 8'h00) begin
      errors++;
      $display("FAIL async_reset ready=%b valid=%b sel=%h exp all 0", bus.req_ready, bus.xbar_valid, bus.xbar_sel);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    set_in(0, 1'b1, 0, 1'b1);
    set_in(1, 1'b1, 0, 1'b1);
    set_in(2, 1'b1, 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle("ar_after");
      checks++;
      if (obs_valid[0] !== (k < 4)) begin
        errors++;
        $display("FAIL ar_after beat %0d valid0 got=%b exp=%b", k, obs_valid[0], (k < 4));
      end
      if (k == 0) begin
        checks++;
        if (obs_sel[0] !== 2'd0) begin errors++; $display("FAIL ar_first sel0 got=%0d exp=0", obs_sel[0]); end
      end
    end
  endtask

  task automatic test_random();
    bit in_pkt[N];
    int pkt_dest[N];
    reset_dut();
    for (int i = 0; i < N; i++) begin
      in_pkt[i]   = 1'b0;
      pkt_dest[i] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!(bus.req_valid[i] && !obs_ready[i]) || n == 0) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req_valid[i] = 1'b0;
          end else begin
            bus.req_valid[i] = 1'b1;
            bus.req_dest[i]  = in_pkt[i] ? 4'(pkt_dest[i]) : 4'($urandom_range(0, 4));
            bus.req_last[i]  = ($urandom_range(0, 2) == 0);
          end
        end
      end
      for (int j = 0; j < N; j++) begin
        bus.credit_return[j] = $urandom_range(0, 1) == 1;
        bus.out_enable[j]    = $urandom_range(0, 9) != 0;
      end
      cycle("random");
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && obs_ready[i] && bus.req_dest[i] < 4'd4) begin
          in_pkt[i]   = !bus.req_last[i];
          pkt_dest[i] = int'(bus.req_dest[i]);
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    obs_ready = 4'b0000;
    reset_model();
    test_reset();
    test_contention();
    test_alternate();
    test_lock();
    test_credits();
    test_illegal();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
